// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong datapath: FSM states, ball home
// position, LCD character codes and screen geometry.
`timescale 1ns/1ps
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int BALL_X0  = 316;
    localparam int BALL_Y0  = 188;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [31:0] PLACAR_RESET = {ASCII_SPACE, ASCII_ZERO, ASCII_COMMA, ASCII_ZERO};

    // LCD score line " P2,P1" packed as four ASCII bytes.
    function automatic logic [31:0] placar_word(input logic [7:0] s1, input logic [7:0] s2);
        return {ASCII_SPACE, 8'(ASCII_ZERO + s2), ASCII_COMMA, 8'(ASCII_ZERO + s1)};
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle trigger into a HOLD-cycle high level; a trigger while
// active restarts the count. Reset leaves the output high for HOLD cycles.
`timescale 1ns/1ps
module pulse_stretch #(
    parameter int HOLD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= CW'(HOLD);
        end else if (trig) begin
            cnt <= CW'(HOLD);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: owns the scores, gates the ball engine, formats the LCD
// score line and detects game over. enable_pong low freezes everything but the strobe.
`timescale 1ns/1ps
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LCD_HOLD     = 3,
    parameter int SCORE_W      = 2
) (
    input  logic               clk_in,
    input  logic               i_rst,
    input  logic               enable_pong,
    input  logic               frame_end,
    input  logic               start_btn,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic               ball_run,
    output logic               ball_recenter,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [31:0]        placar_write,
    output logic               placar_strobe,
    output logic               game_over,
    output logic               winner
);

    localparam int                 FC_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);

    state_t            state;
    state_t            state_nxt;
    logic              start_prev;
    logic              start_rise;
    logic              boot_q;
    logic [FC_W-1:0]   frame_cnt;
    logic              serve_done;
    logic              only_p1;
    logic              only_p2;
    logic              recenter_req;
    logic              load_placar;
    logic              clear_scores;
    logic              clear_frames;

    assign start_rise = start_btn & ~start_prev;
    assign only_p1    = point_p1 & ~point_p2;
    assign only_p2    = point_p2 & ~point_p1;
    assign serve_done = frame_end && (frame_cnt == FC_W'(SERVE_FRAMES - 1));

    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (enable_pong) begin
            case (state)
                ST_IDLE:  if (start_rise) state_nxt = ST_SERVE;
                ST_SERVE: if (serve_done) state_nxt = ST_PLAY;
                ST_PLAY:  if (point_p1 || point_p2) state_nxt = ST_POINT;
                ST_POINT: state_nxt = (score_p1 == WIN || score_p2 == WIN) ? ST_OVER : ST_SERVE;
                ST_OVER:  if (start_rise) state_nxt = ST_SERVE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ball_run     = 1'b0;
        game_over    = 1'b0;
        recenter_req = 1'b0;
        load_placar  = 1'b0;
        clear_scores = 1'b0;
        clear_frames = 1'b0;
        case (state)
            ST_IDLE: begin
                recenter_req = enable_pong & start_rise;
                clear_frames = enable_pong & start_rise;
            end
            ST_PLAY: ball_run = enable_pong;
            ST_POINT: begin
                recenter_req = enable_pong;
                load_placar  = enable_pong;
                clear_frames = enable_pong;
            end
            ST_OVER: begin
                game_over    = 1'b1;
                recenter_req = enable_pong & start_rise;
                load_placar  = enable_pong & start_rise;
                clear_scores = enable_pong & start_rise;
                clear_frames = enable_pong & start_rise;
            end
            default: ;
        endcase
    end

    assign winner        = game_over && (score_p2 == WIN);
    assign ball_recenter = boot_q | recenter_req;

    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            start_prev   <= 1'b0;
            boot_q       <= 1'b1;
            frame_cnt    <= '0;
            score_p1     <= '0;
            score_p2     <= '0;
            serve_dir    <= 1'b0;
            placar_write <= PLACAR_RESET;
        end else begin
            start_prev <= start_btn;
            boot_q     <= 1'b0;
            if (enable_pong) begin
                if (clear_frames) begin
                    frame_cnt <= '0;
                end else if (state == ST_SERVE && frame_end) begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end

                // Loser serves toward the scorer's side; a double hit re-serves unchanged.
                if (clear_scores) begin
                    score_p1 <= '0;
                    score_p2 <= '0;
                end else if (state == ST_PLAY) begin
                    if (only_p1) begin
                        serve_dir <= 1'b1;
                        if (score_p1 < WIN) score_p1 <= score_p1 + SCORE_W'(1);
                    end else if (only_p2) begin
                        serve_dir <= 1'b0;
                        if (score_p2 < WIN) score_p2 <= score_p2 + SCORE_W'(1);
                    end
                end

                if (load_placar) begin
                    placar_write <= clear_scores ? PLACAR_RESET
                                                 : placar_word(8'(score_p1), 8'(score_p2));
                end
            end
        end
    end

    pulse_stretch #(
        .HOLD (LCD_HOLD)
    ) u_placar_strobe (
        .clk   (clk_in),
        .rst   (i_rst),
        .trig  (load_placar),
        .pulse (placar_strobe)
    );

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl with a score/serve reference model.
`timescale 1ns/1ps
module tb_pong_match_ctrl;

    localparam int WIN  = 3;
    localparam int SF   = 60;
    localparam int HOLD = 3;

    logic       clk_in = 1'b0;
    logic       i_rst, enable_pong, frame_end, start_btn, point_p1, point_p2;
    logic       ball_run, ball_recenter, serve_dir, placar_strobe, game_over, winner;
    logic [1:0] score_p1, score_p2;
    logic [31:0] placar_write;

    int checks = 0;
    int errors = 0;

    int          m_s1, m_s2;
    logic        m_dir;
    logic [31:0] m_placar;

    pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .LCD_HOLD(HOLD), .SCORE_W(2)) dut (
        .clk_in(clk_in), .i_rst(i_rst), .enable_pong(enable_pong), .frame_end(frame_end),
        .start_btn(start_btn), .point_p1(point_p1), .point_p2(point_p2),
        .ball_run(ball_run), .ball_recenter(ball_recenter), .serve_dir(serve_dir),
        .score_p1(score_p1), .score_p2(score_p2), .placar_write(placar_write),
        .placar_strobe(placar_strobe), .game_over(game_over), .winner(winner)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] exp_placar(input int s1, input int s2);
        return {8'h20, 8'(48 + s2), 8'h2C, 8'(48 + s1)};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    // n frame_end pulses with random gaps; optional stray point pulses in the gaps
    task automatic run_frames(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if (noise && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) point_p1 = 1'b1;
                    else                           point_p2 = 1'b1;
                end
                step();
                point_p1 = 1'b0;
                point_p2 = 1'b0;
            end
            frame_end = 1'b1;
            step();
            frame_end = 1'b0;
        end
    endtask

    task automatic serve_to_play();
        run_frames(SF - 1, 1'b1);
        checks++;
        if (ball_run !== 1'b0) begin errors++; $display("FAIL serve_early got %b exp 0", ball_run); end
        run_frames(1, 1'b0);
        checks++;
        if (ball_run !== 1'b1) begin errors++; $display("FAIL serve_run got %b exp 1", ball_run); end
    endtask

    // who: 0 = player 1 scores, 1 = player 2 scores, 2 = both pulses together
    task automatic do_point(input int who);
        logic [31:0] old;
        int hi;
        old = m_placar;
        if (who == 0) begin
            if (m_s1 < WIN) m_s1++;
            m_dir = 1'b1;
        end else if (who == 1) begin
            if (m_s2 < WIN) m_s2++;
            m_dir = 1'b0;
        end
        point_p1 = (who != 1);
        point_p2 = (who != 0);
        step();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        checks++;
        if (score_p1 !== 2'(m_s1) || score_p2 !== 2'(m_s2)) begin
            errors++; $display("FAIL point_scores got %0d:%0d exp %0d:%0d", score_p1, score_p2, m_s1, m_s2);
        end
        checks++;
        if (ball_recenter !== 1'b1 || ball_run !== 1'b0) begin
            errors++; $display("FAIL point_recenter got rc=%b run=%b exp rc=1 run=0", ball_recenter, ball_run);
        end
        checks++;
        if (placar_write !== old) begin errors++; $display("FAIL placar_early got %h exp %h", placar_write, old); end
        step();
        m_placar = exp_placar(m_s1, m_s2);
        checks++;
        if (placar_write !== m_placar) begin errors++; $display("FAIL placar_load got %h exp %h", placar_write, m_placar); end
        checks++;
        if (serve_dir !== m_dir) begin errors++; $display("FAIL serve_dir got %b exp %b", serve_dir, m_dir); end
        checks++;
        if (game_over !== (m_s1 == WIN || m_s2 == WIN) || ball_recenter !== 1'b0 || ball_run !== 1'b0) begin
            errors++; $display("FAIL after_point got over=%b rc=%b run=%b exp over=%b rc=0 run=0",
                               game_over, ball_recenter, ball_run, (m_s1 == WIN || m_s2 == WIN));
        end
        if (m_s1 == WIN || m_s2 == WIN) begin
            checks++;
            if (winner !== (m_s2 == WIN)) begin errors++; $display("FAIL winner got %b exp %b", winner, (m_s2 == WIN)); end
        end
        hi = int'(placar_strobe);
        for (int i = 0; i < HOLD; i++) begin
            step();
            hi += int'(placar_strobe);
        end
        checks++;
        if (hi !== HOLD) begin errors++; $display("FAIL strobe_len got %0d exp %0d", hi, HOLD); end
    endtask

    task automatic restart();
        start_btn = 1'b1;
        #1;
        checks++;
        if (ball_recenter !== 1'b1) begin errors++; $display("FAIL restart_recenter got %b exp 1", ball_recenter); end
        step();
        start_btn = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        m_placar = exp_placar(0, 0);
        checks++;
        if (score_p1 !== 2'd0 || score_p2 !== 2'd0 || game_over !== 1'b0 || ball_run !== 1'b0) begin
            errors++; $display("FAIL restart_state got %0d:%0d over=%b run=%b exp 0:0 over=0 run=0",
                               score_p1, score_p2, game_over, ball_run);
        end
        checks++;
        if (placar_write !== m_placar || placar_strobe !== 1'b1) begin
            errors++; $display("FAIL restart_placar got %h stb=%b exp %h stb=1", placar_write, placar_strobe, m_placar);
        end
    endtask

    task automatic test_reset();
        int hi;
        i_rst = 1'b1; enable_pong = 1'b1; frame_end = 1'b0; start_btn = 1'b0;
        point_p1 = 1'b0; point_p2 = 1'b0;
        m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_placar = 32'h20302C30;
        #3;
        checks++;
        if (ball_run !== 1'b0 || score_p1 !== 2'd0 || score_p2 !== 2'd0 || serve_dir !== 1'b0 ||
            game_over !== 1'b0 || winner !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got run=%b sc=%0d:%0d dir=%b over=%b win=%b exp all 0",
                               ball_run, score_p1, score_p2, serve_dir, game_over, winner);
        end
        checks++;
        if (placar_write !== 32'h20302C30) begin errors++; $display("FAIL reset_placar got %h exp 20302c30", placar_write); end
        step();
        step();
        i_rst = 1'b0;
        #1;
        checks++;
        if (ball_recenter !== 1'b1) begin errors++; $display("FAIL boot_recenter got %b exp 1", ball_recenter); end
        hi = int'(placar_strobe);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (ball_recenter !== 1'b0) begin errors++; $display("FAIL boot_recenter_end got %b exp 0", ball_recenter); end
            end
            hi += int'(placar_strobe);
        end
        checks++;
        if (hi !== HOLD) begin errors++; $display("FAIL boot_strobe_len got %0d exp %0d", hi, HOLD); end
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        #1;
        checks++;
        if (ball_recenter !== 1'b1) begin errors++; $display("FAIL start_recenter got %b exp 1", ball_recenter); end
        step();
        checks++;
        if (ball_recenter !== 1'b0 || ball_run !== 1'b0) begin
            errors++; $display("FAIL start_serve got rc=%b run=%b exp rc=0 run=0", ball_recenter, ball_run);
        end
        start_btn = 1'b0;
        serve_to_play();
        checks++;
        if (placar_write !== 32'h20302C30) begin errors++; $display("FAIL start_placar got %h exp 20302c30", placar_write); end
    endtask

    task automatic test_first_point();
        do_point(0);
        checks++;
        if (score_p1 !== 2'd1 || placar_write !== 32'h20302C31 || serve_dir !== 1'b1) begin
            errors++; $display("FAIL first_point got p1=%0d placar=%h dir=%b exp 1 20302c31 1",
                               score_p1, placar_write, serve_dir);
        end
    endtask

    task automatic test_enable();
        run_frames(20, 1'b1);
        enable_pong = 1'b0;
        run_frames(100, 1'b1);
        checks++;
        if (ball_run !== 1'b0 || score_p1 !== 2'(m_s1) || score_p2 !== 2'(m_s2)) begin
            errors++; $display("FAIL disabled_serve got run=%b sc=%0d:%0d exp 0 %0d:%0d", ball_run, score_p1, score_p2, m_s1, m_s2);
        end
        enable_pong = 1'b1;
        serve_to_play_rest();
        enable_pong = 1'b0;
        #1;
        checks++;
        if (ball_run !== 1'b0) begin errors++; $display("FAIL disabled_run got %b exp 0", ball_run); end
        point_p1 = 1'b1;
        step();
        point_p1 = 1'b0;
        checks++;
        if (score_p1 !== 2'(m_s1)) begin errors++; $display("FAIL disabled_point got %0d exp %0d", score_p1, m_s1); end
        enable_pong = 1'b1;
        #1;
        checks++;
        if (ball_run !== 1'b1) begin errors++; $display("FAIL reenabled_run got %b exp 1", ball_run); end
    endtask

    task automatic serve_to_play_rest();
        run_frames(SF - 21, 1'b1);
        checks++;
        if (ball_run !== 1'b0) begin errors++; $display("FAIL resume_early got %b exp 0", ball_run); end
        run_frames(1, 1'b0);
        checks++;
        if (ball_run !== 1'b1) begin errors++; $display("FAIL resume_run got %b exp 1", ball_run); end
    endtask

    task automatic test_both();
        do_point(2);
        serve_to_play();
    endtask

    task automatic test_random_match();
        int n;
        n = 0;
        while (m_s1 < WIN && m_s2 < WIN && n < 20) begin
            int r;
            r = $urandom_range(0, 4);
            do_point(r < 2 ? 0 : (r < 4 ? 1 : 2));
            if (m_s1 < WIN && m_s2 < WIN) serve_to_play();
            n++;
        end
        checks++;
        if (game_over !== 1'b1) begin errors++; $display("FAIL match_end got %b exp 1", game_over); end
    endtask

    task automatic test_over();
        point_p1 = 1'b1; step(); point_p1 = 1'b0;
        point_p2 = 1'b1; step(); point_p2 = 1'b0;
        run_frames(SF + 5, 1'b1);
        checks++;
        if (score_p1 !== 2'(m_s1) || score_p2 !== 2'(m_s2) || game_over !== 1'b1 || ball_run !== 1'b0) begin
            errors++; $display("FAIL over_hold got %0d:%0d over=%b run=%b exp %0d:%0d over=1 run=0",
                               score_p1, score_p2, game_over, ball_run, m_s1, m_s2);
        end
        restart();
        serve_to_play();
    endtask

    task automatic test_p2_wins();
        for (int i = 0; i < WIN; i++) begin
            do_point(1);
            if (i < WIN - 1) serve_to_play();
        end
        checks++;
        if (score_p2 !== 2'd3 || game_over !== 1'b1 || winner !== 1'b1) begin
            errors++; $display("FAIL p2_wins got p2=%0d over=%b win=%b exp 3 1 1", score_p2, game_over, winner);
        end
        restart();
        serve_to_play();
    endtask

    task automatic test_reset_mid_play();
        do_point(0); serve_to_play();
        do_point(1); serve_to_play();
        do_point(0); serve_to_play();
        checks++;
        if (score_p1 !== 2'd2 || score_p2 !== 2'd1) begin
            errors++; $display("FAIL pre_reset got %0d:%0d exp 2:1", score_p1, score_p2);
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if (score_p1 !== 2'd0 || score_p2 !== 2'd0 || ball_run !== 1'b0 || serve_dir !== 1'b0 ||
            placar_write !== 32'h20302C30 || ball_recenter !== 1'b1 || placar_strobe !== 1'b1) begin
            errors++; $display("FAIL async_reset got sc=%0d:%0d run=%b dir=%b placar=%h rc=%b stb=%b exp 0:0 0 0 20302c30 1 1",
                               score_p1, score_p2, ball_run, serve_dir, placar_write, ball_recenter, placar_strobe);
        end
        step();
        step();
        i_rst = 1'b0;
        m_s1 = 0; m_s2 = 0;
        run_frames(SF + 10, 1'b1);
        checks++;
        if (ball_run !== 1'b0 || game_over !== 1'b0 || score_p1 !== 2'd0 || score_p2 !== 2'd0) begin
            errors++; $display("FAIL idle_after_reset got run=%b over=%b sc=%0d:%0d exp 0 0 0:0",
                               ball_run, game_over, score_p1, score_p2);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_first_point();
        test_enable();
        test_both();
        test_random_match();
        test_over();
        test_p2_wins();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
